// File: rtl/button_events.sv
// Per-button conditioner: polarity normalise, 2-FF synchronise, debounce, then
// an event FSM that emits single-cycle press/release/click/long/repeat pulses.
module button_events #(
    parameter int NUM_BTNS        = 3,
    parameter int ACTIVE_HIGH     = 1,
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int LONG_CYCLES     = 6000000,
    parameter int REPEAT_CYCLES   = 1200000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BTNS-1:0] btn_raw,
    output logic [NUM_BTNS-1:0] btn_level,
    output logic [NUM_BTNS-1:0] btn_press,
    output logic [NUM_BTNS-1:0] btn_release,
    output logic [NUM_BTNS-1:0] btn_click,
    output logic [NUM_BTNS-1:0] btn_long,
    output logic [NUM_BTNS-1:0] btn_repeat
);

    localparam int DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    localparam logic [DB_W-1:0]   DB_LIMIT  = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } state_e;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_lane
        logic            pressed_raw;
        logic            sync1_q, sync2_q;
        logic            level_q, level_d;
        logic [DB_W-1:0] db_cnt_q, db_cnt_d;
        logic [HOLD_W-1:0] hold_q;
        state_e          state_q;
        logic            press_q, release_q, click_q, long_q, repeat_q;

        assign pressed_raw = (ACTIVE_HIGH != 0) ? btn_raw[i] : ~btn_raw[i];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
            end else begin
                // NOTE: non-blocking here is what makes this a two-stage chain; blocking would collapse it to one flop.
                sync1_q <= pressed_raw;
                sync2_q <= sync1_q;
            end
        end

        // NOTE: every output of this block gets a default first, so no latch is inferred.
        always_comb begin
            level_d  = level_q;
            db_cnt_d = '0;
            if (sync2_q != level_q) begin
                if (db_cnt_q == DB_LIMIT) begin
                    level_d = ~level_q;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
        end

        // The FSM looks at level_d so events coincide with the first cycle of the new level.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                level_q   <= 1'b0;
                db_cnt_q  <= '0;
                state_q   <= IDLE;
                hold_q    <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                click_q   <= 1'b0;
                long_q    <= 1'b0;
                repeat_q  <= 1'b0;
            end else begin
                level_q   <= level_d;
                db_cnt_q  <= db_cnt_d;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                click_q   <= 1'b0;
                long_q    <= 1'b0;
                repeat_q  <= 1'b0;
                case (state_q)
                    IDLE: begin
                        if (level_d) begin
                            press_q <= 1'b1;
                            hold_q  <= '0;
                            state_q <= PRESSED;
                        end
                    end
                    PRESSED: begin
                        // NOTE: the release test comes first so a fall on the limit cycle suppresses long.
                        if (!level_d) begin
                            release_q <= 1'b1;
                            click_q   <= 1'b1;
                            state_q   <= IDLE;
                        end else if (hold_q == LONG_LAST) begin
                            long_q  <= 1'b1;
                            hold_q  <= '0;
                            state_q <= HELD;
                        end else begin
                            hold_q <= hold_q + 1'b1;
                        end
                    end
                    HELD: begin
                        if (!level_d) begin
                            release_q <= 1'b1;
                            state_q   <= IDLE;
                        end else if (REPEAT_CYCLES != 0) begin
                            if (hold_q == REP_LAST) begin
                                repeat_q <= 1'b1;
                                hold_q   <= '0;
                            end else begin
                                hold_q <= hold_q + 1'b1;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
        assign btn_click[i]   = click_q;
        assign btn_long[i]    = long_q;
        assign btn_repeat[i]  = repeat_q;
    end

endmodule
